tff_count_ctrl: RTL and testbench

//  Sequencer for an external bank of WIDTH toggle flip-flops (t in, q out) that turns it into a mod-(MAX+1) up/down counter.

---
 rtl/tff_count_ctrl_if.sv | 10 +
 rtl/tff_count_ctrl.sv | 97 +++++++++
 tb/tb_tff_count_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tff_count_ctrl_if.sv
// rtl/tff_count_ctrl_if.sv - toggle-enable / state link between the sequencer and its TFF bank
interface tff_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] t_out;

    modport master (input q_in, output t_out);
    modport slave (input t_out, output q_in);
endinterface

// File: rtl/tff_count_ctrl.sv
// rtl/tff_count_ctrl.sv - drives an external T flip-flop bank as a mod-(MAX+1) up/down counter
module tff_count_ctrl #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    tff_count_ctrl_if.master   bank,
    output logic               busy,
    output logic               tc
);
    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] up_nxt;
    logic [WIDTH-1:0] dn_nxt;
    logic [WIDTH-1:0] nxt;
    logic             wrap;

    assign q = bank.q_in;

    // Out-of-range bank values snap to 0 (up) or MAX (down) without flagging a wrap.
    always_comb begin
        up_nxt = (q >= MAX_W) ? '0 : q + 1'b1;
        dn_nxt = (q == '0 || q > MAX_W) ? MAX_W : q - 1'b1;
        nxt    = dir ? up_nxt : dn_nxt;
        wrap   = (state == S_RUN) && (dir ? (q == MAX_W) : (q == '0));
    end

    always_comb begin
        bank.t_out = '0;
        case (state)
            S_CLEAR: bank.t_out = q;
            S_RUN:   bank.t_out = q ^ nxt;
            default: bank.t_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
            busy  <= 1'b1;
            tc    <= 1'b0;
        end else if (clr) begin
            state <= S_CLEAR;
            busy  <= 1'b1;
            tc    <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    tc <= 1'b0;
                    if (q == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        busy  <= 1'b1;
                    end
                end
                S_IDLE: begin
                    tc <= 1'b0;
                    if (!stop && start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // The step driven this cycle still lands, so its wrap is still reported.
                    tc <= wrap;
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    busy  <= 1'b1;
                    tc    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb/tb_tff_count_ctrl.sv - directed checks of tff_count_ctrl driving a behavioural TFF bank
module tb_tff_count_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       start;
    logic       stop;
    logic       dir;
    logic       busy;
    logic       tc;
    logic [3:0] q = 4'hF;
    logic       force_en;
    logic [3:0] force_val;
    int         n_checks = 0;
    int         n_fail = 0;

    tff_count_ctrl_if #(.WIDTH(4)) bif ();

    tff_count_ctrl #(.WIDTH(4), .MAX(9)) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .start (start),
        .stop  (stop),
        .dir   (dir),
        .bank  (bif.master),
        .busy  (busy),
        .tc    (tc)
    );

    always #5 clk = ~clk;

    // Behavioural TFF bank; force_en lets the bench preload arbitrary values.
    always @(posedge clk) begin
        if (force_en) q <= force_val;
        else          q <= q ^ bif.t_out;
    end
    assign bif.q_in = q;

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %0b want 1", busy); end
        n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc got %0b want 0", tc); end
        n_checks++; if (bif.t_out !== 4'hF) begin n_fail++; $display("FAIL reset_clear_t got %h want f", bif.t_out); end
        rst = 1'b0; force_en = 1'b0;
        @(negedge clk);
        n_checks++; if (q !== 4'h0) begin n_fail++; $display("FAIL clear_q got %h want 0", q); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy got %0b want 1", busy); end
        n_checks++; if (bif.t_out !== 4'h0) begin n_fail++; $display("FAIL clear_t0 got %h want 0", bif.t_out); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %0b want 0", busy); end
        n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL idle_tc got %0b want 0", tc); end
        n_checks++; if (q !== 4'h0) begin n_fail++; $display("FAIL idle_q got %h want 0", q); end
    endtask

    task automatic test_count_up;
        logic [3:0] exp_q  [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        logic       exp_tc [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        start = 1'b1; dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL up_start_busy got %0b want 1", busy); end
        n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL up_start_q got %h want 0", q); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL up_q[%0d] got %0d want %0d", i, q, exp_q[i]); end
            n_checks++; if (tc !== exp_tc[i]) begin n_fail++; $display("FAIL up_tc[%0d] got %0b want %0b", i, tc, exp_tc[i]); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL up_busy[%0d] got %0b want 1", i, busy); end
        end
    endtask

    task automatic test_count_down;
        logic [3:0] exp_q  [7] = '{4'd1, 4'd0, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5};
        logic       exp_tc [7] = '{0, 0, 1, 0, 0, 0, 0};
        dir = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_checks++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL dn_q[%0d] got %0d want %0d", i, q, exp_q[i]); end
            n_checks++; if (tc !== exp_tc[i]) begin n_fail++; $display("FAIL dn_tc[%0d] got %0b want %0b", i, tc, exp_tc[i]); end
        end
    endtask

    task automatic test_stop;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++; if (q !== 4'd4) begin n_fail++; $display("FAIL stop_step_q got %0d want 4", q); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %0b want 0", busy); end
        @(negedge clk);
        n_checks++; if (q !== 4'd4) begin n_fail++; $display("FAIL stop_hold_q got %0d want 4", q); end
        n_checks++; if (bif.t_out !== 4'd0) begin n_fail++; $display("FAIL stop_hold_t got %h want 0", bif.t_out); end
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_idle_busy got %0b want 0", busy); end
        @(negedge clk);
        n_checks++; if (q !== 4'd4) begin n_fail++; $display("FAIL both_idle_q got %0d want 4", q); end
        start = 1'b1; dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++; if (q !== 4'd5) begin n_fail++; $display("FAIL resume_q got %0d want 5", q); end
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        n_checks++; if (q !== 4'd6) begin n_fail++; $display("FAIL both_run_q got %0d want 6", q); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_run_busy got %0b want 0", busy); end
        @(negedge clk);
        n_checks++; if (q !== 4'd6) begin n_fail++; $display("FAIL both_run_hold got %0d want 6", q); end
    endtask

    task automatic test_clear;
        start = 1'b1; dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++; if (q !== 4'd7) begin n_fail++; $display("FAIL clr_pre_q got %0d want 7", q); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy got %0b want 1", busy); end
        n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL clr_tc got %0b want 0", tc); end
        n_checks++; if (bif.t_out !== 4'd8) begin n_fail++; $display("FAIL clr_t got %h want 8", bif.t_out); end
        @(negedge clk);
        n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL clr_q got %0d want 0", q); end
        n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL clr_tc2 got %0b want 0", tc); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_out_of_range;
        force_en = 1'b1; force_val = 4'd13;
        @(negedge clk);
        force_en = 1'b0;
        n_checks++; if (bif.t_out !== 4'd0) begin n_fail++; $display("FAIL oor_idle_t got %h want 0", bif.t_out); end
        start = 1'b1; dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (bif.t_out !== 4'd13) begin n_fail++; $display("FAIL oor_up_t got %h want d", bif.t_out); end
        @(negedge clk);
        n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL oor_up_q got %0d want 0", q); end
        n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL oor_up_tc got %0b want 0", tc); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++; if (q !== 4'd1) begin n_fail++; $display("FAIL oor_stop_q got %0d want 1", q); end
        force_en = 1'b1; force_val = 4'd13;
        @(negedge clk);
        force_en = 1'b0;
        start = 1'b1; dir = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (bif.t_out !== 4'd4) begin n_fail++; $display("FAIL oor_dn_t got %h want 4", bif.t_out); end
        @(negedge clk);
        n_checks++; if (q !== 4'd9) begin n_fail++; $display("FAIL oor_dn_q got %0d want 9", q); end
        n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL oor_dn_tc got %0b want 0", tc); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++; if (q !== 4'd8) begin n_fail++; $display("FAIL oor_dn_stop_q got %0d want 8", q); end
    endtask

    task automatic test_reset_midrun;
        start = 1'b1; dir = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_run_busy got %0b want 1", busy); end
        n_checks++; if (q !== 4'd9) begin n_fail++; $display("FAIL rst_run_q got %0d want 9", q); end
        n_checks++; if (bif.t_out !== 4'd9) begin n_fail++; $display("FAIL rst_run_t got %h want 9", bif.t_out); end
        @(negedge clk);
        n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL rst_run_zero got %0d want 0", q); end
        n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL rst_run_tc got %0b want 0", tc); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_run_idle got %0b want 0", busy); end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b1;
        force_en = 1'b1; force_val = 4'hF;
        test_reset();
        test_count_up();
        test_count_down();
        test_stop();
        test_clear();
        test_out_of_range();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
